snake_dir_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 39 +++
 rtl/snake_dir_ctrl_if.sv | 25 ++
 rtl/snake_dir_fifo.sv | 89 ++++++++
 rtl/snake_dir_ctrl.sv | 123 ++++++++++++
 tb/tb_snake_dir_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants and helpers for the snake direction controller.
package snake_pkg;

  // Direction codes; the opposite direction always differs in bit 0 only.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Key vector bit positions.
  localparam int KEY_UP      = 0;
  localparam int KEY_DOWN    = 1;
  localparam int KEY_LEFT    = 2;
  localparam int KEY_RIGHT   = 3;
  localparam int KEY_PAUSE   = 4;
  localparam int KEY_RESTART = 5;
  localparam int KEY_W       = 6;

  // 180-degree reversal of a direction.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

  // Highest-priority direction among simultaneous presses: up > down > left > right.
  function automatic logic [1:0] pick_dir(input logic [3:0] p);
    logic [1:0] d;
    if (p[KEY_UP]) begin
      d = DIR_UP;
    end else if (p[KEY_DOWN]) begin
      d = DIR_DOWN;
    end else if (p[KEY_LEFT]) begin
      d = DIR_LEFT;
    end else begin
      d = DIR_RIGHT;
    end
    return d;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Key inputs and game-command outputs between the debouncer, this controller and the snake core.
interface snake_dir_ctrl_if;
  import snake_pkg::*;

  logic [KEY_W-1:0] key_n;
  logic             tick;
  logic [1:0]       dir;
  logic             step;
  logic             paused;
  logic             restart_pulse;
  logic [KEY_W-1:0] key_press;
  logic             dir_drop;

  // Stimulus side (debouncer + step timer).
  modport master (
    output key_n, tick,
    input  dir, step, paused, restart_pulse, key_press, dir_drop
  );

  // Controller side.
  modport slave (
    input  key_n, tick,
    output dir, step, paused, restart_pulse, key_press, dir_drop
  );
endinterface

// File: rtl/snake_dir_fifo.sv
// Small FIFO of pending direction changes; push and pop may coincide even when full.
module snake_dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic [1:0] i_din,
  output logic [1:0] o_head,
  output logic [1:0] o_tail,
  output logic       o_empty,
  output logic       o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_tail_ptr;

  // Pointer advance with wrap at the configured depth (not a power of two in general).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign o_empty    = (r_count == {CNT_W{1'b0}});
  assign o_full     = (r_count == FULL_CNT);
  assign w_pop_ok   = i_pop & ~o_empty;
  // A full FIFO still takes a push when the same cycle pops.
  assign w_push_ok  = i_push & (~o_full | w_pop_ok);
  assign w_tail_ptr = (r_wr_ptr == {PTR_W{1'b0}}) ? LAST_PTR : r_wr_ptr - PTR_W'(1);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_tail     = r_mem[w_tail_ptr];

  // Storage write; contents cleared on reset so head/tail are never X.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 2'b00;
      end
    end else if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_din;
    end else begin
      r_mem <= r_mem;
    end
  end

  // Read/write pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Key-to-command controller: press detection, direction queueing, pause and restart.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         DIR_FIFO_DEPTH = 2,
  parameter logic [1:0] INIT_DIR       = 2'b11
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  snake_dir_ctrl_if.slave   bus
);

  logic [KEY_W-1:0] r_key_prev;
  logic [KEY_W-1:0] r_key_press;
  logic [1:0]       r_dir;
  logic             r_step;
  logic             r_paused;
  logic             r_restart_pulse;
  logic             r_dir_drop;

  logic [KEY_W-1:0] w_press;
  logic             w_restart;
  logic             w_pause_tgl;
  logic             w_dir_req;
  logic             w_tick_act;
  logic [1:0]       w_cand;
  logic [1:0]       w_ref;
  logic             w_reject;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [1:0]       w_fifo_head;
  logic [1:0]       w_fifo_tail;
  logic             w_fifo_empty;
  logic             w_fifo_full;

  // Falling edge of an active-low key is a press.
  assign w_press     = r_key_prev & ~bus.key_n;
  // Restart overrides everything else seen in the same cycle.
  assign w_restart   = w_press[KEY_RESTART];
  assign w_pause_tgl = w_press[KEY_PAUSE] & ~w_restart;
  // Direction presses and ticks are frozen by the current pause level.
  assign w_dir_req   = (|w_press[KEY_RIGHT:KEY_UP]) & ~r_paused & ~w_restart;
  assign w_tick_act  = bus.tick & ~r_paused & ~w_restart;
  assign w_cand      = pick_dir(w_press[KEY_RIGHT:KEY_UP]);
  // New direction is judged against the last queued one, or the live one when nothing is queued.
  assign w_ref       = w_fifo_empty ? r_dir : w_fifo_tail;
  assign w_reject    = (w_cand == w_ref) | (w_cand == opposite(w_ref));
  assign w_pop       = w_tick_act & ~w_fifo_empty;
  assign w_push      = w_dir_req & ~w_reject & (~w_fifo_full | w_pop);
  assign w_drop      = w_dir_req & ~w_reject & w_fifo_full & ~w_pop;

  snake_dir_fifo #(
    .DEPTH (DIR_FIFO_DEPTH)
  ) u_fifo (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_restart),
    .i_din     (w_cand),
    .o_head    (w_fifo_head),
    .o_tail    (w_fifo_tail),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  // Key history and registered per-key press pulses.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_prev  <= {KEY_W{1'b1}};
      r_key_press <= {KEY_W{1'b0}};
    end else begin
      r_key_prev  <= bus.key_n;
      r_key_press <= w_press;
    end
  end

  // Current direction and move strobe; dir changes in the same cycle step rises.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dir  <= INIT_DIR;
      r_step <= 1'b0;
    end else if (w_restart) begin
      r_dir  <= INIT_DIR;
      r_step <= 1'b0;
    end else begin
      r_step <= w_tick_act;
      if (w_pop) begin
        r_dir <= w_fifo_head;
      end else begin
        r_dir <= r_dir;
      end
    end
  end

  // Pause level plus restart and drop strobes.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_paused        <= 1'b0;
      r_restart_pulse <= 1'b0;
      r_dir_drop      <= 1'b0;
    end else begin
      r_restart_pulse <= w_restart;
      r_dir_drop      <= w_drop;
      if (w_restart) begin
        r_paused <= 1'b0;
      end else if (w_pause_tgl) begin
        r_paused <= ~r_paused;
      end else begin
        r_paused <= r_paused;
      end
    end
  end

  assign bus.dir           = r_dir;
  assign bus.step          = r_step;
  assign bus.paused        = r_paused;
  assign bus.restart_pulse = r_restart_pulse;
  assign bus.key_press     = r_key_press;
  assign bus.dir_drop      = r_dir_drop;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench: directed vector table, hand sequences and random stimulus vs a queue model.
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  localparam int         DEPTH = 2;
  localparam logic [1:0] INIT  = 2'b11;

  localparam logic [5:0] K_NONE  = 6'h3F;
  localparam logic [5:0] K_UP    = 6'h3E;
  localparam logic [5:0] K_DOWN  = 6'h3D;
  localparam logic [5:0] K_LEFT  = 6'h3B;
  localparam logic [5:0] K_RIGHT = 6'h37;
  localparam logic [5:0] K_PAUSE = 6'h2F;
  localparam logic [5:0] K_RST   = 6'h1F;

  typedef struct packed {
    logic [1:0] dir;
    logic       step;
    logic       paused;
    logic       rp;
    logic [5:0] kp;
    logic       drop;
  } out_t;

  typedef struct {
    logic [5:0] key_n;
    logic       tick;
    out_t       exp;
  } vec_t;

  logic pixel_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  snake_dir_ctrl_if bus ();

  snake_dir_ctrl #(
    .DIR_FIFO_DEPTH (DEPTH),
    .INIT_DIR       (INIT)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: plain queue of pending directions.
  logic [5:0] m_prev;
  logic [1:0] m_dir;
  logic       m_paused;
  logic [1:0] m_q[$];
  out_t       m_exp;

  vec_t tbl[$];

  function automatic out_t mko(input logic [1:0] d, input logic s, input logic p,
                               input logic r, input logic [5:0] kp, input logic dr);
    out_t o;
    o.dir = d; o.step = s; o.paused = p; o.rp = r; o.kp = kp; o.drop = dr;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [5:0] k, input logic t, input out_t e);
    vec_t v;
    v.key_n = k; v.tick = t; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {bus.dir, bus.step, bus.paused, bus.restart_pulse, bus.key_press, bus.dir_drop};
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got dir=%b step=%b paused=%b restart=%b key_press=%b drop=%b, want dir=%b step=%b paused=%b restart=%b key_press=%b drop=%b",
               name, act.dir, act.step, act.paused, act.rp, act.kp, act.drop,
               exp.dir, exp.step, exp.paused, exp.rp, exp.kp, exp.drop);
    end
  endtask

  task automatic model_reset();
    m_prev   = 6'h3F;
    m_dir    = INIT;
    m_paused = 1'b0;
    m_q.delete();
    m_exp    = mko(INIT, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
  endtask

  // One cycle of game rules: restart wins, pause level gates directions and ticks.
  task automatic model_step(input logic [5:0] k, input logic t);
    logic [5:0] p;
    logic [1:0] cand;
    logic [1:0] refd;
    logic       found;
    logic       pop_now;
    logic       popped;
    logic       new_paused;
    p      = m_prev & ~k;
    m_prev = k;
    m_exp  = mko(2'b00, 1'b0, 1'b0, 1'b0, p, 1'b0);
    if (p[5]) begin
      m_dir    = INIT;
      m_paused = 1'b0;
      m_q.delete();
      m_exp.rp = 1'b1;
    end else begin
      new_paused = m_paused ^ p[4];
      if (!m_paused) begin
        pop_now = t && (m_q.size() > 0);
        popped  = 1'b0;
        found   = 1'b0;
        cand    = 2'b00;
        for (int i = 0; i < 4; i++) begin
          if (p[i] && !found) begin
            found = 1'b1;
            cand  = 2'(i);
          end
        end
        if (found) begin
          refd = (m_q.size() > 0) ? m_q[$] : m_dir;
          if (cand != refd && cand != (refd ^ 2'b01)) begin
            if (m_q.size() < DEPTH || pop_now) begin
              if (pop_now) begin
                m_dir  = m_q.pop_front();
                popped = 1'b1;
              end
              m_q.push_back(cand);
            end else begin
              m_exp.drop = 1'b1;
            end
          end
        end
        if (t) begin
          m_exp.step = 1'b1;
          if (pop_now && !popped) m_dir = m_q.pop_front();
        end
      end
      m_paused = new_paused;
    end
    m_exp.dir    = m_dir;
    m_exp.paused = m_paused;
  endtask

  // Apply inputs for one clock, then compare against the model on the falling edge.
  task automatic drive(input logic [5:0] k, input logic t);
    bus.key_n = k;
    bus.tick  = t;
    model_step(k, t);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    check("model", m_exp);
  endtask

  task automatic reset_dut(input logic [5:0] k);
    @(negedge pixel_clk);
    sys_rst_n = 1'b0;
    bus.key_n = k;
    bus.tick  = 1'b0;
    model_reset();
    repeat (2) @(negedge pixel_clk);
    check("reset", mko(INIT, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0));
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] k;
    logic       t;
    int         r;
    bus.key_n = K_NONE;
    bus.tick  = 1'b0;
    model_reset();

    // Directed vectors: inputs for one cycle, outputs expected after that edge.
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_UP,   1'b0, mko(2'b11, 0, 0, 0, 6'h01, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_LEFT, 1'b0, mko(2'b11, 0, 0, 0, 6'h04, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b00, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b10, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_RST,  1'b0, mko(2'b11, 0, 0, 1, 6'h20, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_LEFT, 1'b0, mko(2'b11, 0, 0, 0, 6'h04, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b11, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_UP,   1'b0, mko(2'b11, 0, 0, 0, 6'h01, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_LEFT, 1'b0, mko(2'b11, 0, 0, 0, 6'h04, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_DOWN, 1'b0, mko(2'b11, 0, 0, 0, 6'h02, 1)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b00, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_PAUSE,1'b0, mko(2'b10, 0, 1, 0, 6'h10, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 0, 1, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_UP,   1'b0, mko(2'b10, 0, 1, 0, 6'h01, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 0, 1, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_PAUSE,1'b0, mko(2'b10, 0, 0, 0, 6'h10, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_UP,   1'b0, mko(2'b10, 0, 0, 0, 6'h01, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b10, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_RIGHT,1'b0, mko(2'b10, 0, 0, 0, 6'h08, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b10, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_PAUSE,1'b0, mko(2'b10, 0, 1, 0, 6'h10, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b10, 0, 1, 0, 6'h00, 0)));
    tbl.push_back(mkv(6'h0F,  1'b0, mko(2'b11, 0, 0, 1, 6'h30, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b11, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_UP,   1'b0, mko(2'b11, 0, 0, 0, 6'h01, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_LEFT, 1'b0, mko(2'b11, 0, 0, 0, 6'h04, 0)));
    tbl.push_back(mkv(K_NONE, 1'b0, mko(2'b11, 0, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_DOWN, 1'b1, mko(2'b00, 1, 0, 0, 6'h02, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b01, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b01, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(K_LEFT, 1'b1, mko(2'b01, 1, 0, 0, 6'h04, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b10, 1, 0, 0, 6'h00, 0)));
    tbl.push_back(mkv(6'h3C,  1'b0, mko(2'b10, 0, 0, 0, 6'h03, 0)));
    tbl.push_back(mkv(K_NONE, 1'b1, mko(2'b00, 1, 0, 0, 6'h00, 0)));

    reset_dut(K_NONE);

    // Idle keys, tick every 10 cycles: direction constant, step one cycle after each tick.
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 9; j++) begin
        drive(K_NONE, 1'b0);
        check("idle", mko(2'b11, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0));
      end
      drive(K_NONE, 1'b1);
      check("idle_tick", mko(2'b11, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].key_n, tbl[i].tick);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Up held low across reset release: exactly one press, then queued up is applied.
    reset_dut(K_UP);
    drive(K_UP, 1'b0);
    check("held_first", mko(2'b11, 1'b0, 1'b0, 1'b0, 6'h01, 1'b0));
    drive(K_UP, 1'b0);
    check("held_steady", mko(2'b11, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0));
    drive(K_UP, 1'b1);
    check("held_tick", mko(2'b00, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0));
    drive(K_NONE, 1'b0);

    // Random key activity checked against the queue model.
    reset_dut(K_NONE);
    for (int c = 0; c < 3000; c++) begin
      k = K_NONE;
      r = $urandom_range(0, 99);
      if (r < 45) k[$urandom_range(0, 3)] = 1'b0;
      if (r < 10) k[$urandom_range(0, 3)] = 1'b0;
      if (r == 95 || r == 96) k[4] = 1'b0;
      if (r == 99) k[5] = 1'b0;
      t = ($urandom_range(0, 2) == 0);
      drive(k, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
